// File: rtl/csr_unit.sv
// Machine-mode CSR file: atomic CSR ops, 64-bit counters with inhibit, irq gating,
// and trap/mret stacking of mstatus. Reads are combinational and always return the pre-write value.
module csr_unit #(
    parameter int              XLEN      = 32,
    parameter int              NUM_HPM   = 2,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               csr_req_i,
    input  logic [1:0]         csr_op_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    output logic [XLEN-1:0]    csr_rdata_o,
    output logic               csr_illegal_o,
    input  logic               trap_i,
    input  logic [XLEN-1:0]    trap_cause_i,
    input  logic [XLEN-1:0]    trap_pc_i,
    input  logic               mret_i,
    input  logic               retire_i,
    input  logic [NUM_HPM-1:0] hpm_event_i,
    input  logic               irq_sw_i,
    input  logic               irq_timer_i,
    input  logic               irq_ext_i,
    output logic [XLEN-1:0]    mtvec_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic               irq_pending_o
);

    localparam int NCNT = NUM_HPM + 2;
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888);

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csrOp_e;

    // Counter 0 is mcycle, 1 is minstret, 2+k is mhpmcounter(3+k); the offset doubles as the inhibit bit.
    function automatic int cntOffset(input int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    logic                  mstatusMie_q, mstatusMie_d;
    logic                  mstatusMpie_q, mstatusMpie_d;
    logic [XLEN-1:0]       mie_q, mie_d;
    logic [XLEN-1:0]       mtvec_q, mtvec_d;
    logic [XLEN-1:0]       mscratch_q, mscratch_d;
    logic [XLEN-1:0]       mepc_q, mepc_d;
    logic [XLEN-1:0]       mcause_q, mcause_d;
    logic [XLEN-1:0]       inhibit_q, inhibit_d;
    logic [2:0]            mip_q;
    logic [63:0]           cnt_q [NCNT];
    logic [63:0]           cnt_d [NCNT];

    logic [XLEN-1:0]       mstatusRd;
    logic [XLEN-1:0]       mipRd;
    logic [XLEN-1:0]       inhibitMask;
    logic [XLEN-1:0]       oldVal;
    logic [XLEN-1:0]       newVal;
    logic                  mapped;
    logic                  effWrite;
    logic                  isIllegal;
    logic                  doWrite;
    logic [NCNT-1:0]       cntInc;

    assign cntInc = {hpm_event_i, retire_i, 1'b1};

    always_comb begin
        mstatusRd        = '0;
        mstatusRd[12:11] = 2'b11;
        mstatusRd[7]     = mstatusMpie_q;
        mstatusRd[3]     = mstatusMie_q;
        mipRd            = '0;
        mipRd[3]         = mip_q[0];
        mipRd[7]         = mip_q[1];
        mipRd[11]        = mip_q[2];
        inhibitMask      = '0;
        for (int i = 0; i < NCNT; i++) begin
            inhibitMask[cntOffset(i)] = 1'b1;
        end
    end

    always_comb begin
        oldVal = '0;
        mapped = 1'b1;
        case (csr_addr_i)
            12'h300: oldVal = mstatusRd;
            12'h304: oldVal = mie_q;
            12'h305: oldVal = mtvec_q;
            12'h320: oldVal = inhibit_q;
            12'h340: oldVal = mscratch_q;
            12'h341: oldVal = mepc_q;
            12'h342: oldVal = mcause_q;
            12'h344: oldVal = mipRd;
            12'hC00: oldVal = XLEN'(cnt_q[0][31:0]);
            12'hC80: oldVal = XLEN'(cnt_q[0][63:32]);
            12'hC02: oldVal = XLEN'(cnt_q[1][31:0]);
            12'hC82: oldVal = XLEN'(cnt_q[1][63:32]);
            12'hF14: oldVal = HART_ID;
            default: mapped = 1'b0;
        endcase
        for (int i = 0; i < NCNT; i++) begin
            if (csr_addr_i == 12'hB00 + 12'(cntOffset(i))) begin
                mapped = 1'b1;
                oldVal = XLEN'(cnt_q[i][31:0]);
            end
            if (csr_addr_i == 12'hB80 + 12'(cntOffset(i))) begin
                mapped = 1'b1;
                oldVal = XLEN'(cnt_q[i][63:32]);
            end
        end
    end

    // Set/clear with a zero operand is a pure read, so it stays legal on read-only CSRs.
    always_comb begin
        effWrite = csr_req_i && (csr_op_i != OP_READ)
                   && !(csr_op_i[1] && (csr_wdata_i == '0));
        isIllegal = csr_req_i && (!mapped || (effWrite && (csr_addr_i[11:10] == 2'b11)));
        doWrite   = effWrite && !isIllegal && !trap_i && !mret_i;
        case (csr_op_i)
            OP_RW:   newVal = csr_wdata_i;
            OP_RS:   newVal = oldVal | csr_wdata_i;
            OP_RC:   newVal = oldVal & ~csr_wdata_i;
            default: newVal = oldVal;
        endcase
    end

    assign csr_rdata_o   = isIllegal ? '0 : oldVal;
    assign csr_illegal_o = isIllegal;

    always_comb begin
        mstatusMie_d  = mstatusMie_q;
        mstatusMpie_d = mstatusMpie_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        inhibit_d     = inhibit_q;
        if (trap_i) begin
            mepc_d        = {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_d      = trap_cause_i;
            mstatusMpie_d = mstatusMie_q;
            mstatusMie_d  = 1'b0;
        end else if (mret_i) begin
            mstatusMie_d  = mstatusMpie_q;
            mstatusMpie_d = 1'b1;
        end else if (doWrite) begin
            case (csr_addr_i)
                12'h300: begin
                    mstatusMie_d  = newVal[3];
                    mstatusMpie_d = newVal[7];
                end
                12'h304: mie_d      = newVal & MIE_MASK;
                12'h305: mtvec_d    = {newVal[XLEN-1:2], 1'b0, newVal[0]};
                12'h320: inhibit_d  = newVal & inhibitMask;
                12'h340: mscratch_d = newVal;
                12'h341: mepc_d     = {newVal[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = newVal;
                default: ;
            endcase
        end
    end

    // A software write to either half replaces that half and suppresses the increment for the cycle.
    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (doWrite && (csr_addr_i == 12'hB00 + 12'(cntOffset(i)))) begin
                cnt_d[i] = {cnt_q[i][63:32], newVal[31:0]};
            end else if (doWrite && (csr_addr_i == 12'hB80 + 12'(cntOffset(i)))) begin
                cnt_d[i] = {newVal[31:0], cnt_q[i][31:0]};
            end else if (cntInc[i] && !inhibit_q[cntOffset(i)]) begin
                cnt_d[i] = cnt_q[i] + 64'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatusMie_q  <= 1'b0;
            mstatusMpie_q <= 1'b0;
            mie_q         <= '0;
            mtvec_q       <= MTVEC_RST;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            inhibit_q     <= '0;
            mip_q         <= '0;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            mstatusMie_q  <= mstatusMie_d;
            mstatusMpie_q <= mstatusMpie_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            inhibit_q     <= inhibit_d;
            mip_q         <= {irq_ext_i, irq_timer_i, irq_sw_i};
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = (|(mipRd & mie_q)) && mstatusMie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: every CSR access is one cycle, driven 1ns after the rising edge
// and checked 2ns after it; expected values are hand-computed.
module tb_csr_unit;

    localparam logic [31:0] HART  = 32'h0000_0005;
    localparam logic [31:0] MTVR  = 32'h8000_0001;
    localparam logic [1:0]  RD    = 2'b00;
    localparam logic [1:0]  RW    = 2'b01;
    localparam logic [1:0]  RS    = 2'b10;
    localparam logic [1:0]  RC    = 2'b11;

    logic        clk;
    logic        rst;
    logic        csrReq;
    logic [1:0]  csrOp;
    logic [11:0] csrAddr;
    logic [31:0] csrWdata;
    logic [31:0] csrRdata;
    logic        csrIllegal;
    logic        trap;
    logic [31:0] trapCause;
    logic [31:0] trapPc;
    logic        mret;
    logic        retire;
    logic [1:0]  hpmEvent;
    logic        irqSw;
    logic        irqTimer;
    logic        irqExt;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        irqPending;

    int assertCount = 0;
    int failCount   = 0;

    csr_unit #(
        .XLEN(32),
        .NUM_HPM(2),
        .HART_ID(HART),
        .MTVEC_RST(MTVR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .csr_req_i(csrReq),
        .csr_op_i(csrOp),
        .csr_addr_i(csrAddr),
        .csr_wdata_i(csrWdata),
        .csr_rdata_o(csrRdata),
        .csr_illegal_o(csrIllegal),
        .trap_i(trap),
        .trap_cause_i(trapCause),
        .trap_pc_i(trapPc),
        .mret_i(mret),
        .retire_i(retire),
        .hpm_event_i(hpmEvent),
        .irq_sw_i(irqSw),
        .irq_timer_i(irqTimer),
        .irq_ext_i(irqExt),
        .mtvec_o(mtvec),
        .mepc_o(mepc),
        .irq_pending_o(irqPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [1:0] op, input logic [11:0] addr,
                                 input logic [31:0] wdata);
        csrReq   = req;
        csrOp    = op;
        csrAddr  = addr;
        csrWdata = wdata;
        #1;
    endtask

    // Advance to 1ns after the next rising edge and drop all one-cycle strobes.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        csrReq   = 1'b0;
        csrOp    = RD;
        trap     = 1'b0;
        mret     = 1'b0;
        retire   = 1'b0;
        hpmEvent = 2'b00;
    endtask

    task automatic access(input string tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wdata, input bit checkRd, input logic [31:0] expRd,
                          input logic expIll);
        applyStimulus(1'b1, op, addr, wdata);
        if (checkRd) checkOutput({tag, ".rdata"}, csrRdata, expRd);
        checkOutput({tag, ".illegal"}, {31'b0, csrIllegal}, {31'b0, expIll});
        nextCycle();
    endtask

    initial begin
        rst = 1'b1; csrReq = 0; csrOp = RD; csrAddr = '0; csrWdata = '0;
        trap = 0; trapCause = '0; trapPc = '0; mret = 0; retire = 0; hpmEvent = '0;
        irqSw = 0; irqTimer = 0; irqExt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst.mtvec_o", mtvec, MTVR);
        checkOutput("rst.mepc_o", mepc, 32'h0);
        checkOutput("rst.irq_pending", {31'b0, irqPending}, 32'h0);
        access("rst.mcycle0", RD, 12'hB00, 0, 1, 32'd0, 0);
        access("rst.mcycle1", RD, 12'hB00, 0, 1, 32'd1, 0);
        access("rst.mcycle2", RD, 12'hB00, 0, 1, 32'd2, 0);
        access("rst.mstatus", RD, 12'h300, 0, 1, 32'h1800, 0);
        access("rst.mtvec", RD, 12'h305, 0, 1, MTVR, 0);
        access("rst.mhartid", RD, 12'hF14, 0, 1, HART, 0);

        access("rs.mstatus", RS, 12'h300, 32'h8, 1, 32'h1800, 0);
        access("rs.mstatus.rd", RD, 12'h300, 0, 1, 32'h1808, 0);
        access("rc.mstatus", RC, 12'h300, 32'h8, 1, 32'h1808, 0);
        access("rc.mstatus.rd", RD, 12'h300, 0, 1, 32'h1800, 0);
        access("rs0.mhartid", RS, 12'hF14, 0, 1, HART, 0);
        access("rw.mhartid", RW, 12'hF14, 1, 1, 32'h0, 1);
        access("rw.cycle", RW, 12'hC00, 1, 1, 32'h0, 1);
        access("rd.7c0", RD, 12'h7C0, 0, 1, 32'h0, 1);
        access("rd.b01", RD, 12'hB01, 0, 1, 32'h0, 1);
        access("rd.c03", RD, 12'hC03, 0, 1, 32'h0, 1);
        access("mhartid.kept", RD, 12'hF14, 0, 1, HART, 0);

        access("rw.mtvec", RW, 12'h305, 32'hFFFF_FFFF, 1, MTVR, 0);
        access("rw.mtvec.rd", RD, 12'h305, 0, 1, 32'hFFFF_FFFD, 0);
        checkOutput("mtvec_o", mtvec, 32'hFFFF_FFFD);
        access("rw.mepc", RW, 12'h341, 32'h123, 1, 32'h0, 0);
        access("rw.mepc.rd", RD, 12'h341, 0, 1, 32'h120, 0);
        access("rw.mscratch", RW, 12'h340, 32'h1234, 1, 32'h0, 0);
        access("rw.mscratch.rd", RD, 12'h340, 0, 1, 32'h1234, 0);

        access("trap.prep", RS, 12'h300, 32'h8, 1, 32'h1800, 0);
        trap = 1; trapCause = 32'h8000_000B; trapPc = 32'h103;
        access("trap.exwrite", RW, 12'h341, 32'hABC, 1, 32'h120, 0);
        checkOutput("trap.mepc_o", mepc, 32'h100);
        access("trap.mepc", RD, 12'h341, 0, 1, 32'h100, 0);
        access("trap.mcause", RD, 12'h342, 0, 1, 32'h8000_000B, 0);
        access("trap.mstatus", RD, 12'h300, 0, 1, 32'h1880, 0);
        mret = 1;
        applyStimulus(1'b0, RD, 12'h0, 0);
        nextCycle();
        access("mret.mstatus", RD, 12'h300, 0, 1, 32'h1888, 0);

        access("rw.mie", RW, 12'h304, 32'hFFFF_FFFF, 1, 32'h0, 0);
        access("rw.mie.rd", RD, 12'h304, 0, 1, 32'h888, 0);
        access("rw.mie.ext", RW, 12'h304, 32'h800, 1, 32'h888, 0);
        irqExt = 1;
        #1 checkOutput("irq.latency", {31'b0, irqPending}, 32'h0);
        nextCycle();
        checkOutput("irq.pending", {31'b0, irqPending}, 32'h1);
        access("mip.rd", RD, 12'h344, 0, 1, 32'h800, 0);
        access("mip.rw", RW, 12'h344, 32'h0, 1, 32'h800, 0);
        access("mip.kept", RD, 12'h344, 0, 1, 32'h800, 0);
        access("irq.mie_off", RC, 12'h300, 32'h8, 1, 32'h1888, 0);
        checkOutput("irq.gated", {31'b0, irqPending}, 32'h0);
        irqExt = 0;

        access("trapmret.prep", RS, 12'h300, 32'h8, 1, 32'h1880, 0);
        trap = 1; mret = 1; trapCause = 32'h3; trapPc = 32'h200;
        applyStimulus(1'b0, RD, 12'h0, 0);
        nextCycle();
        access("trapmret.mstatus", RD, 12'h300, 0, 1, 32'h1880, 0);
        access("trapmret.mcause", RD, 12'h342, 0, 1, 32'h3, 0);
        checkOutput("trapmret.mepc_o", mepc, 32'h200);

        access("wrap.lo", RW, 12'hB00, 32'hFFFF_FFFF, 0, 32'h0, 0);
        access("wrap.hi", RW, 12'hB80, 32'hFFFF_FFFF, 1, 32'h0, 0);
        access("wrap.ones", RD, 12'hB00, 0, 1, 32'hFFFF_FFFF, 0);
        access("wrap.lo0", RD, 12'hB00, 0, 1, 32'h0, 0);
        access("wrap.hi0", RD, 12'hB80, 0, 1, 32'h0, 0);
        access("wrap.cycle", RD, 12'hC00, 0, 1, 32'h2, 0);
        access("wrap.cycleh", RD, 12'hC80, 0, 1, 32'h0, 0);

        access("instret.clr", RW, 12'hB02, 0, 1, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            retire = 1;
            applyStimulus(1'b0, RD, 12'h0, 0);
            nextCycle();
        end
        access("instret.cnt", RD, 12'hB02, 0, 1, 32'h3, 0);
        retire = 1;
        access("instret.wrinc", RW, 12'hB02, 32'h10, 1, 32'h3, 0);
        access("instret.wrwin", RD, 12'hB02, 0, 1, 32'h10, 0);
        access("instret.user", RD, 12'hC02, 0, 1, 32'h10, 0);
        for (int i = 0; i < 2; i++) begin
            hpmEvent = 2'b10;
            applyStimulus(1'b0, RD, 12'h0, 0);
            nextCycle();
        end
        access("hpm4", RD, 12'hB04, 0, 1, 32'h2, 0);
        access("hpm3", RD, 12'hB03, 0, 1, 32'h0, 0);
        access("hpm4h", RD, 12'hB84, 0, 1, 32'h0, 0);

        access("inh.cy", RS, 12'h320, 32'h1, 1, 32'h0, 0);
        access("inh.wr", RW, 12'hB00, 32'h55, 0, 32'h0, 0);
        repeat (3) begin
            applyStimulus(1'b0, RD, 12'h0, 0);
            nextCycle();
        end
        access("inh.frozen", RD, 12'hB00, 0, 1, 32'h55, 0);
        access("inh.all", RW, 12'h320, 32'hFFFF_FFFF, 1, 32'h1, 0);
        access("inh.mask", RD, 12'h320, 0, 1, 32'h1D, 0);
        retire = 1;
        applyStimulus(1'b0, RD, 12'h0, 0);
        nextCycle();
        access("inh.instret", RD, 12'hB02, 0, 1, 32'h10, 0);

        applyStimulus(1'b1, RW, 12'h340, 32'hDEAD);
        checkOutput("rstmid.legal", {31'b0, csrIllegal}, 32'h0);
        #1 rst = 1'b1;
        csrReq = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rstmid.mtvec_o", mtvec, MTVR);
        checkOutput("rstmid.mepc_o", mepc, 32'h0);
        access("rstmid.mscratch", RD, 12'h340, 0, 1, 32'h0, 0);
        access("rstmid.mstatus", RD, 12'h300, 0, 1, 32'h1800, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
